fetch_unit: RTL and testbench

- Instruction-fetch initiator for the RISC-V core. Drives the valid/ready word-read port of the on-chip program memory (one port of the dual-port ROM).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake, each word tagged with its PC.
- Handles redirects (branch/jump/trap) by flushing buffered words and discarding responses still in flight.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_if.sv | 54 +++++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit shared widths and types.
// Holds the RISC-V width defines used across the fetch slice.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_INSTR_BYTES
`define RISCV_INSTR_BYTES 4
`endif

package fetch_unit_pkg;

  localparam int unsigned WORD_W = `RISCV_WORD_WIDTH;
  localparam int unsigned INSTR_BYTES = `RISCV_INSTR_BYTES;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_PUSH,
    RESP_DROP
  } resp_act_e;

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: memory read port, redirect, decode port.
// FETCH_MISALIGN_CHK_EN adds instr_misaligned_o.
interface fetch_if #(
  parameter int unsigned AW = `RISCV_ADDR_WIDTH,
  parameter int unsigned WW = `RISCV_WORD_WIDTH
);

  logic          mem_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready_i;
  logic [WW-1:0] mem_rdata_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_addr_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [WW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic          instr_misaligned_o;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHK_EN
    output instr_misaligned_o,
`endif
    output mem_valid_o,
    output mem_addr_o,
    input  mem_ready_i,
    input  mem_rdata_i,
    input  redirect_i,
    input  redirect_addr_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
    input  instr_misaligned_o,
`endif
    input  mem_valid_o,
    input  mem_addr_o,
    output mem_ready_i,
    output mem_rdata_i,
    output redirect_i,
    output redirect_addr_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush.
// Head data is read combinationally from the array.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, PC tagging, redirect.
// FETCH_MISALIGN_CHK_EN reports misaligned redirect targets.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = `RISCV_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_CHK_EN
  localparam int unsigned EW = 1 + AW + WORD_W;
`else
  localparam int unsigned EW = AW + WORD_W;
`endif

  logic          run_q;
  logic [CW-1:0] out_q;
  logic [CW-1:0] out_next;
  logic [CW-1:0] drop_q;
  logic [AW-1:0] fetch_pc_q;
  logic [AW-1:0] resp_pc_q;
  logic [AW-1:0] tgt_pc;
  logic [CW:0]   credit;
  logic          issue;
  logic          resp_ok;
  resp_act_e     act;
  logic          halt;
  logic          mis_pend;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic          fifo_full;
  logic [CW-1:0] fifo_cnt;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          unused_addr_lsbs;

  assign tgt_pc = {bus.redirect_addr_i[AW-1:2], 2'b00};
  assign unused_addr_lsbs = ^bus.redirect_addr_i[1:0];

  assign credit = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign issue  = run_q && !halt
               && (credit < (CW+1)'(FIFO_DEPTH));

  assign resp_ok = bus.mem_ready_i && (out_q != '0);

  // Classify the memory response for this cycle.
  always_comb begin
    act = RESP_NONE;
    if (resp_ok) begin
      if (bus.redirect_i || drop_q != '0) begin
        act = RESP_DROP;
      end else begin
        act = RESP_PUSH;
      end
    end
  end

  // Outstanding count after this cycle's issue and response.
  always_comb begin
    out_next = out_q;
    unique case ({issue, resp_ok})
      2'b10:   out_next = out_q + 1'b1;
      2'b01:   out_next = out_q - 1'b1;
      default: out_next = out_q;
    endcase
  end

  // Fetch PC, response PC, credits and drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      out_q      <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      run_q <= 1'b1;
      out_q <= out_next;
      if (bus.redirect_i) begin
        drop_q     <= out_next;
        fetch_pc_q <= tgt_pc;
        resp_pc_q  <= tgt_pc;
      end else begin
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + AW'(INSTR_BYTES);
        end
        if (act == RESP_PUSH) begin
          resp_pc_q <= resp_pc_q + AW'(INSTR_BYTES);
        end
        if (act == RESP_DROP) begin
          drop_q <= drop_q - 1'b1;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic          halt_q;
  logic          mis_pend_q;
  logic [AW-1:0] mis_pc_q;
  logic          mis_tgt;

  assign mis_tgt  = bus.redirect_i
                 && (bus.redirect_addr_i[1:0] != 2'b00);
  assign halt     = halt_q;
  assign mis_pend = mis_pend_q;

  // Misaligned target: halt fetch, queue one marker entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q     <= 1'b0;
      mis_pend_q <= 1'b0;
      mis_pc_q   <= '0;
    end else if (bus.redirect_i) begin
      halt_q     <= mis_tgt;
      mis_pend_q <= mis_tgt;
      mis_pc_q   <= bus.redirect_addr_i;
    end else begin
      mis_pend_q <= 1'b0;
    end
  end

  assign wdata = mis_pend
    ? {1'b1, mis_pc_q, {WORD_W{1'b0}}}
    : {1'b0, resp_pc_q, bus.mem_rdata_i};
  assign bus.instr_misaligned_o = head_valid && rdata[EW-1];
`else
  assign halt     = 1'b0;
  assign mis_pend = 1'b0;
  assign wdata    = {resp_pc_q, bus.mem_rdata_i};
`endif

  assign push = mis_pend || (act == RESP_PUSH);
  assign pop  = head_valid && bus.instr_ready_i
             && !bus.redirect_i;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .wdata (wdata),
    .rdata (rdata),
    .count (fifo_cnt),
    .full  (fifo_full)
  );

  assign head_valid = (fifo_cnt != '0);

  assign bus.mem_valid_o   = issue;
  assign bus.mem_addr_o    = fetch_pc_q;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid
    ? rdata[WORD_W-1:0] : '0;
  assign bus.instr_pc_o    = head_valid
    ? rdata[AW+WORD_W-1:WORD_W] : '0;

  // The credit rule must never let a push meet a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: vector table, directed redirects,
// random-latency memory with a PC/data scoreboard.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.AW(32), .WW(32)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;
  int lat_max = 1;

  function automatic logic [31:0] rom(logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic head(string n, logic v, logic [31:0] pc);
    chk({n, " valid"}, 32'(bus.instr_valid_o), 32'(v));
    if (v) begin
      chk({n, " pc"}, bus.instr_pc_o, pc);
      chk({n, " instr"}, bus.instr_o, rom(pc));
    end
  endtask

  task automatic mreq(string n, logic v, logic [31:0] a);
    chk({n, " mem_valid"}, 32'(bus.mem_valid_o), 32'(v));
    if (v) chk({n, " mem_addr"}, bus.mem_addr_o, a);
  endtask

  // In-order memory model with 1..lat_max cycle latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t rq[$];
  int mcyc = 0;
  int last_due = 0;

  always @(negedge clk) begin
    int d;
    mcyc++;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    if (rst) begin
      rq.delete();
      last_due = 0;
    end else begin
      if (rq.size() > 0 && rq[0].due <= mcyc) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = rom(rq[0].addr);
        void'(rq.pop_front());
      end
      if (bus.mem_valid_o) begin
        d = mcyc + int'($urandom_range(lat_max, 1));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        rq.push_back('{bus.mem_addr_o, d});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_addr_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        mv;
    logic [31:0] maddr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[19];

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    int pops;

    // Startup, 10-cycle stall, then drain with 1-cycle ROM.
    vt[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    vt[3]  = '{1'b0, 1'b1, 32'h10c, 1'b1, 32'h104};
    vt[4]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h104};
    for (int i = 5; i <= 12; i++)
      vt[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h104};
    vt[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
    vt[14] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h108};
    vt[15] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h10c};
    vt[16] = '{1'b1, 1'b1, 32'h11c, 1'b1, 32'h110};
    vt[17] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
    vt[18] = '{1'b1, 1'b1, 32'h124, 1'b1, 32'h118};

    bus.instr_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("rst mem_valid", 32'(bus.mem_valid_o), 0);
    chk("rst instr_valid", 32'(bus.instr_valid_o), 0);
    chk("rst instr", bus.instr_o, 0);
    chk("rst pc", bus.instr_pc_o, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst mis", 32'(bus.instr_misaligned_o), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      mreq($sformatf("v%0d", i), vt[i].mv, vt[i].maddr);
      head($sformatf("v%0d", i), vt[i].iv, vt[i].pc);
      bus.instr_ready_i = vt[i].rdy;
    end

    // Redirect with an issue, a response and a pop together.
    do_reset();
    repeat (4) @(negedge clk);
    mreq("r1 pre", 1'b1, 32'h10c);
    head("r1 pre", 1'b1, 32'h100);
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 32'h200;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    mreq("r1 c1", 1'b1, 32'h200);
    head("r1 c1", 1'b0, 32'h0);
    @(negedge clk);
    mreq("r1 c2", 1'b1, 32'h204);
    head("r1 c2", 1'b0, 32'h0);
    @(negedge clk);
    head("r1 c3", 1'b1, 32'h200);
    @(negedge clk);
    head("r1 c4", 1'b1, 32'h204);
    @(negedge clk);
    head("r1 c5", 1'b1, 32'h208);

    // Redirect to 0x302 with FIFO holding 3, one in flight.
    do_reset();
    repeat (5) @(negedge clk);
    mreq("r2 pre", 1'b0, 32'h0);
    head("r2 pre", 1'b1, 32'h100);
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 32'h302;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    head("r2 c1", 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    mreq("r2 c1", 1'b0, 32'h0);
    @(negedge clk);
    mreq("r2 c2", 1'b0, 32'h0);
    chk("r2 mis valid", 32'(bus.instr_valid_o), 1);
    chk("r2 mis pc", bus.instr_pc_o, 32'h302);
    chk("r2 mis instr", bus.instr_o, 0);
    chk("r2 mis flag", 32'(bus.instr_misaligned_o), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mreq($sformatf("r2 halt%0d", i), 1'b0, 32'h0);
      head($sformatf("r2 halt%0d", i), 1'b0, 32'h0);
    end
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = 32'h400;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    mreq("r2 resume", 1'b1, 32'h400);
    repeat (2) @(negedge clk);
    head("r2 resume", 1'b1, 32'h400);
    chk("r2 resume mis", 32'(bus.instr_misaligned_o), 0);
`else
    mreq("r2 c1", 1'b1, 32'h300);
    @(negedge clk);
    mreq("r2 c2", 1'b1, 32'h304);
    head("r2 c2", 1'b0, 32'h0);
    @(negedge clk);
    head("r2 c3", 1'b1, 32'h300);
    @(negedge clk);
    head("r2 c4", 1'b1, 32'h304);
`endif

    // Random latency, ready and redirects against a scoreboard.
    lat_max = 3;
    do_reset();
    exp_pc = 32'h100;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.instr_valid_o) begin
        chk("sb pc", bus.instr_pc_o, exp_pc);
        chk("sb instr", bus.instr_o, rom(exp_pc));
`ifdef FETCH_MISALIGN_CHK_EN
        chk("sb mis", 32'(bus.instr_misaligned_o), 0);
`endif
      end
      bus.instr_ready_i = ($urandom_range(99, 0) < 70);
      bus.redirect_i = ($urandom_range(99, 0) < 4);
      if (bus.redirect_i) begin
        if ($urandom_range(3, 0) == 0)
          tgt = 32'hffff_fff0;
        else
          tgt = 32'h800 + ($urandom_range(255, 0) << 2);
        bus.redirect_addr_i = tgt;
        exp_pc = tgt;
      end else if (bus.instr_valid_o
                   && bus.instr_ready_i) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    chk("sb progress", 32'(pops > 600), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
